// File: rtl/score_event_scheduler.sv
// Score event scheduler: queues per-source score events and feeds the shared
// score ALU one operation per cycle, round-robin between sources. A level-complete
// event expands into an uninterruptible burst of +10 operations.
module score_event_scheduler #(
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_n,     // active-high despite the name
    input  logic       ev_pellet,
    input  logic       ev_power,
    input  logic       ev_ghost,
    input  logic       ev_double,
    input  logic       ev_level,
    input  logic       hold,
    output logic [1:0] alu_select,
    output logic       alu_enable,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned NSRC    = 5;
    localparam int unsigned SRC_LVL = 4;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [NSRC-1:0]  ev;
    logic [CNT_W-1:0] cnt_q [NSRC];
    logic [CNT_W-1:0] cnt_d [NSRC];
    logic [NSRC-1:0]  dec;

    logic [0:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] burst_q, burst_d;
    logic [1:0] alu_select_q, alu_select_d;
    logic       alu_enable_q, alu_enable_d;
    logic       overflow_q, overflow_d;

    logic       found;
    logic [2:0] winner;
    logic [2:0] cand;

    assign ev = {ev_level, ev_double, ev_ghost, ev_power, ev_pellet};

    // Operation code issued to the ALU for each source; level maps to +10.
    function automatic logic [1:0] src_select(input logic [2:0] src);
        logic [1:0] sel;
        case (src)
            3'd0:    sel = 2'b00;
            3'd1:    sel = 2'b01;
            3'd2:    sel = 2'b10;
            3'd3:    sel = 2'b11;
            default: sel = 2'b10;
        endcase
        return sel;
    endfunction

    // Round-robin search: first non-zero counter starting at the pointer.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            cand = 3'((32'(ptr_q) + 32'(i)) % 32'(NSRC));
            if (!found && (cnt_q[cand] != '0)) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // FSM: grant one source per edge in idle, or keep issuing the level burst.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        burst_d      = burst_q;
        alu_enable_d = 1'b0;
        alu_select_d = alu_select_q;
        dec          = '0;
        case (state_q)
            StIdle: begin
                if (!hold && found) begin
                    alu_enable_d = 1'b1;
                    alu_select_d = src_select(winner);
                    dec[winner]  = 1'b1;
                    ptr_d        = (winner == 3'(SRC_LVL)) ? 3'd0 : winner + 3'd1;
                    // The grant edge itself is the first burst op; burst_q counts the rest.
                    if ((winner == 3'(SRC_LVL)) && (BURST_LEN > 1)) begin
                        state_d = StBurst;
                        burst_d = 4'(BURST_LEN - 1);
                    end
                end
            end
            StBurst: begin
                if (!hold) begin
                    alu_enable_d = 1'b1;
                    alu_select_d = 2'b10;
                    burst_d      = burst_q - 4'd1;
                    if (burst_q == 4'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pending counters: a same-edge event and grant cancel; saturate and flag at max.
    always_comb begin
        overflow_d = overflow_q;
        for (int i = 0; i < int'(NSRC); i++) begin
            cnt_d[i] = cnt_q[i];
            if (ev[i] && !dec[i]) begin
                if (cnt_q[i] == CntMax) begin
                    overflow_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (!ev[i] && dec[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // State registers; reset discards pending events and any burst in flight.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            burst_q      <= '0;
            alu_select_q <= 2'b00;
            alu_enable_q <= 1'b0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < int'(NSRC); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            burst_q      <= burst_d;
            alu_select_q <= alu_select_d;
            alu_enable_q <= alu_enable_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < int'(NSRC); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign alu_select = alu_select_q;
    assign alu_enable = alu_enable_q;
    assign overflow   = overflow_q;
    // found is true exactly when some counter is non-zero.
    assign busy       = found || (state_q == StBurst) || alu_enable_q;

endmodule
